// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and SPI mode constants for spi_slave_stream.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // mode = cpol*2 + cpha
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

endpackage

// File: rtl/spi_slave_stream_synchronizer.sv
// synchronizer: multi-stage flop chain bringing asynchronous pins into clk.
module synchronizer #(
    parameter int Width  = 3,
    parameter int Stages = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave_stream.sv
// spi_slave_stream: oversampling SPI slave bridging SPI pins to rx/tx streams.
// Define SPI_SLAVE_STREAM_ERR_EN to enable the sticky overrun/underrun flags.
import spi_pkg::*;

module spi_slave_stream #(
    parameter int                  MaxWidth   = 32,
    parameter int                  LenWidth   = 5,
    parameter int                  SyncStages = 2,
    parameter int                  SPOL       = 0,
    parameter int                  MSB_FIRST  = 1,
    parameter logic [MaxWidth-1:0] FillValue  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_cpol,
    input  logic                cfg_cpha,
    input  logic [LenWidth-1:0] cfg_len_m1,
    output logic [MaxWidth-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic [MaxWidth-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                ssel,
    input  logic                sclk,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    output logic                busy,
    output logic                overrun,
    output logic                underrun,
    input  logic                err_clear
);

    localparam logic SelAct = (SPOL != 0);
    localparam bit   Msb    = (MSB_FIRST != 0);

    logic ssel_s, sclk_s, mosi_s;

    synchronizer #(
        .Width (3),
        .Stages(SyncStages)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  ({ssel, sclk, mosi}),
        .q_o  ({ssel_s, sclk_s, mosi_s})
    );

    state_t              state_q;
    logic                armed_q, sclk_q, mosi_q;
    logic                lead_q, trail_q, cpol_q, cpha_q;
    logic                reload_q, skip_q, rx_valid_q;
    logic [LenWidth-1:0] len_q, cnt_q, len_d;
    logic [MaxWidth-1:0] rx_sh_q, rx_data_q, tx_sh_q;
    logic [MaxWidth-1:0] rx_nxt, tx_d;

    logic sel, in_shift, sample_en, shift_en;
    logic load_en, word_done, rx_take;
    logic lead_d, trail_d;

    assign sel     = (ssel_s == SelAct);
    assign lead_d  = (sclk_s != sclk_q) && (sclk_s != cpol_q);
    assign trail_d = (sclk_s != sclk_q) && (sclk_s == cpol_q);

    assign in_shift  = (state_q == SHIFT) && sel;
    assign sample_en = in_shift && (cpha_q ? trail_q : lead_q);
    assign shift_en  = in_shift && (cpha_q ? lead_q : trail_q);
    assign word_done = sample_en && (cnt_q == len_q);
    assign rx_take   = word_done && (!rx_valid_q || rx_ready);

    // The first shift after a completed word fetches the next tx word.
    assign load_en = ((state_q == LOAD) && sel)
                   || (shift_en && reload_q && !skip_q);
    assign tx_ready = load_en && tx_valid;

    always_comb begin
        len_d = cfg_len_m1;
        if (cfg_len_m1 == '0) begin
            len_d = LenWidth'(1);
        end else if ({1'b0, cfg_len_m1} >= (LenWidth+1)'(MaxWidth)) begin
            len_d = LenWidth'(MaxWidth - 1);
        end
    end

    always_comb begin
        rx_nxt = rx_sh_q;
        if (Msb) begin
            rx_nxt = {rx_sh_q[MaxWidth-2:0], mosi_q};
        end else begin
            rx_nxt[cnt_q] = mosi_q;
        end
    end

    always_comb begin
        tx_d = tx_sh_q;
        if (load_en) begin
            tx_d = tx_valid ? tx_data : FillValue;
        end else if (shift_en && !skip_q) begin
            tx_d = Msb ? (tx_sh_q << 1) : (tx_sh_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            lead_q     <= 1'b0;
            trail_q    <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            reload_q   <= 1'b0;
            skip_q     <= 1'b0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            sclk_q  <= sclk_s;
            mosi_q  <= mosi_s;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            tx_sh_q <= tx_d;
            // After reset a frame may only start on a fresh ssel assertion.
            if (!sel) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (sel && armed_q) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (!sel) begin
                        state_q <= IDLE;
                    end else begin
                        cpol_q   <= cfg_cpol;
                        cpha_q   <= cfg_cpha;
                        len_q    <= len_d;
                        cnt_q    <= '0;
                        rx_sh_q  <= '0;
                        reload_q <= 1'b0;
                        skip_q   <= cfg_cpha;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!sel) begin
                        state_q <= IDLE;
                    end else begin
                        if (word_done) begin
                            cnt_q    <= '0;
                            rx_sh_q  <= '0;
                            reload_q <= 1'b1;
                        end else if (sample_en) begin
                            cnt_q   <= cnt_q + LenWidth'(1);
                            rx_sh_q <= rx_nxt;
                        end
                        if (shift_en && skip_q) begin
                            skip_q <= 1'b0;
                        end else if (shift_en) begin
                            reload_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (rx_take) begin
                rx_data_q  <= rx_nxt;
                rx_valid_q <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_STREAM_ERR_EN
    logic overrun_q, underrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (word_done && !rx_take) begin
                overrun_q <= 1'b1;
            end else if (err_clear) begin
                overrun_q <= 1'b0;
            end
            if (load_en && !tx_valid) begin
                underrun_q <= 1'b1;
            end else if (err_clear) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign overrun  = overrun_q;
    assign underrun = underrun_q;
`else
    logic unused_err;
    assign unused_err = err_clear;
    assign overrun    = 1'b0;
    assign underrun   = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign miso_oe  = busy;
    assign miso     = busy && (Msb ? tx_sh_q[len_q] : tx_sh_q[0]);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: directed bit-banged SPI master against spi_slave_stream.
import spi_pkg::*;

module tb_spi_slave_stream;

    localparam int H = 8;
`ifdef SPI_SLAVE_STREAM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_cpol = 1'b0;
    logic        cfg_cpha = 1'b0;
    logic [4:0]  cfg_len_m1 = 5'd7;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        ssel = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, busy, overrun, underrun;
    logic        err_clear = 1'b0;

    int vecs = 0;
    int errs = 0;
    int tx_pulses = 0;
    int rx_rises = 0;
    logic rxv_d = 1'b0;
    logic [31:0] rx_log[$];
    logic [31:0] tx_words[$];

    spi_slave_stream dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_cpol  (cfg_cpol),
        .cfg_cpha  (cfg_cpha),
        .cfg_len_m1(cfg_len_m1),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ssel      (ssel),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .busy      (busy),
        .overrun   (overrun),
        .underrun  (underrun),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    // Producer: advance to the next queued tx word after each handshake.
    always @(negedge clk) begin
        if (tx_ready) begin
            tx_pulses++;
            @(posedge clk);
            #1;
            if (tx_words.size() > 0) begin
                tx_data = tx_words.pop_front();
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        if (rx_valid && !rxv_d) rx_rises++;
        rxv_d = rx_valid;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
        $fatal(1);
    end

    task automatic prep(input logic v, input logic [31:0] d0,
                        input logic [31:0] d1, input int n);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        tx_words.delete();
        if (n > 1) tx_words.push_back(d1);
        tx_data  = d0;
        tx_valid = v;
        rx_log.delete();
        tx_pulses = 0;
        rx_rises  = 0;
        @(negedge clk);
    endtask

    task automatic spi_frame(input logic [1:0] mode, input logic [4:0] m1,
                             input int len, input int nbits,
                             input logic [31:0] w0, input logic [31:0] w1,
                             output logic [31:0] r0, output logic [31:0] r1);
        logic cpol, cpha, b;
        int wi, bi;
        cpol = mode[1];
        cpha = mode[0];
        r0 = '0;
        r1 = '0;
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        cfg_len_m1 = m1;
        sclk = cpol;
        repeat (H) @(negedge clk);
        ssel = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            wi = i / len;
            bi = len - 1 - (i % len);
            b  = (wi == 0) ? w0[bi] : w1[bi];
            if (!cpha) mosi = b;
            repeat (H) @(negedge clk);
            sclk = ~cpol;
            if (cpha) mosi = b;
            else if (wi == 0) r0 = {r0[30:0], miso};
            else r1 = {r1[30:0], miso};
            repeat (H) @(negedge clk);
            sclk = cpol;
            if (cpha && wi == 0) r0 = {r0[30:0], miso};
            else if (cpha) r1 = {r1[30:0], miso};
        end
        repeat (H) @(negedge clk);
        ssel = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vecs++;
        if ({rx_data, rx_valid, tx_ready, miso, miso_oe, busy,
             overrun, underrun} !== 39'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rx_data, rx_valid, tx_ready, miso, miso_oe, busy,
                      overrun, underrun});
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_mode0;
        logic [31:0] r0, r1;
        prep(1'b1, 32'hA5, 32'h0, 1);
        spi_frame(MODE0, 5'd7, 8, 8, 32'h3C, 32'h0, r0, r1);
        vecs++;
        if (rx_log.size() !== 1) begin
            errs++;
            $display("FAIL m0_rx_count: got %0d want 1", rx_log.size());
        end
        vecs++;
        if ((rx_log.size() > 0 ? rx_log[0] : 32'hDEAD) !== 32'h3C) begin
            errs++;
            $display("FAIL m0_rx_data: got %h want 3c",
                     rx_log.size() > 0 ? rx_log[0] : 32'hDEAD);
        end
        vecs++;
        if (r0[7:0] !== 8'hA5) begin
            errs++;
            $display("FAIL m0_miso: got %h want a5", r0[7:0]);
        end
        vecs++;
        if (tx_pulses !== 1) begin
            errs++;
            $display("FAIL m0_tx_ready: got %0d pulses want 1", tx_pulses);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r0, r1;
        prep(1'b1, 32'hCAFE, 32'h0F0F, 2);
        spi_frame(MODE3, 5'd15, 16, 32, 32'h1234, 32'hBEEF, r0, r1);
        vecs++;
        if (rx_log.size() !== 2) begin
            errs++;
            $display("FAIL b2b_rx_count: got %0d want 2", rx_log.size());
        end
        vecs++;
        if ((rx_log.size() > 1 ? {rx_log[0], rx_log[1]} : 64'h0)
            !== {32'h1234, 32'hBEEF}) begin
            errs++;
            $display("FAIL b2b_rx_data: got %p want 1234,beef", rx_log);
        end
        vecs++;
        if ({r0[15:0], r1[15:0]} !== 32'hCAFE_0F0F) begin
            errs++;
            $display("FAIL b2b_miso: got %h/%h want cafe/0f0f",
                     r0[15:0], r1[15:0]);
        end
        vecs++;
        if ({overrun, underrun} !== 2'b00) begin
            errs++;
            $display("FAIL b2b_flags: got %b want 00", {overrun, underrun});
        end
        vecs++;
        if (tx_pulses !== 2) begin
            errs++;
            $display("FAIL b2b_tx_ready: got %0d pulses want 2", tx_pulses);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] r0, r1;
        prep(1'b1, 32'h11, 32'h22, 2);
        rx_ready = 1'b0;
        spi_frame(MODE1, 5'd7, 8, 16, 32'h5A, 32'h96, r0, r1);
        vecs++;
        if ({rx_valid, rx_data} !== {1'b1, 32'h5A}) begin
            errs++;
            $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=5a",
                     rx_valid, rx_data);
        end
        vecs++;
        if (rx_rises !== 1) begin
            errs++;
            $display("FAIL ovr_rises: got %0d want 1", rx_rises);
        end
        vecs++;
        if ({overrun, underrun} !== {ERR, 1'b0}) begin
            errs++;
            $display("FAIL ovr_flags: got %b want %b",
                     {overrun, underrun}, {ERR, 1'b0});
        end
        vecs++;
        if ({r0[7:0], r1[7:0]} !== 16'h1122) begin
            errs++;
            $display("FAIL ovr_miso: got %h/%h want 11/22", r0[7:0], r1[7:0]);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        vecs++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_clear: got %b want 0", overrun);
        end
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ((rx_log.size() == 1 ? rx_log[0] : 32'hDEAD) !== 32'h5A) begin
            errs++;
            $display("FAIL ovr_drain: got %p want 5a", rx_log);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] r0, r1;
        prep(1'b0, 32'hFF, 32'h0, 1);
        spi_frame(MODE0, 5'd7, 8, 8, 32'h81, 32'h0, r0, r1);
        vecs++;
        if (r0[7:0] !== 8'h00) begin
            errs++;
            $display("FAIL und_miso: got %h want 00", r0[7:0]);
        end
        vecs++;
        if (underrun !== ERR) begin
            errs++;
            $display("FAIL und_flag: got %b want %b", underrun, ERR);
        end
        vecs++;
        if (tx_pulses !== 0) begin
            errs++;
            $display("FAIL und_tx_ready: got %0d pulses want 0", tx_pulses);
        end
        vecs++;
        if ((rx_log.size() == 1 ? rx_log[0] : 32'hDEAD) !== 32'h81) begin
            errs++;
            $display("FAIL und_rx: got %p want 81", rx_log);
        end
    endtask

    task automatic test_abort;
        logic [31:0] r0, r1;
        prep(1'b0, 32'h0, 32'h0, 1);
        spi_frame(MODE2, 5'd4, 5, 3, 32'h0B, 32'h0, r0, r1);
        vecs++;
        if ({busy, miso_oe} !== 2'b00) begin
            errs++;
            $display("FAIL abort_busy: got %b want 00", {busy, miso_oe});
        end
        vecs++;
        if (rx_rises !== 0) begin
            errs++;
            $display("FAIL abort_rx: got %0d words want 0", rx_rises);
        end
        spi_frame(MODE2, 5'd4, 5, 5, 32'h15, 32'h0, r0, r1);
        vecs++;
        if ((rx_log.size() == 1 ? rx_log[0] : 32'hDEAD) !== 32'h15) begin
            errs++;
            $display("FAIL abort_next: got %p want 15", rx_log);
        end
    endtask

    task automatic test_min_len;
        logic [31:0] r0, r1;
        prep(1'b1, 32'h3, 32'h0, 1);
        spi_frame(MODE0, 5'd0, 2, 2, 32'h2, 32'h0, r0, r1);
        vecs++;
        if ((rx_log.size() == 1 ? rx_log[0] : 32'hDEAD) !== 32'h2) begin
            errs++;
            $display("FAIL len0_rx: got %p want 2", rx_log);
        end
        vecs++;
        if (r0[1:0] !== 2'b11) begin
            errs++;
            $display("FAIL len0_miso: got %b want 11", r0[1:0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r0, r1;
        prep(1'b1, 32'hA5, 32'h0, 1);
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        cfg_len_m1 = 5'd7;
        ssel = 1'b0;
        repeat (H) @(negedge clk);
        sclk = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
        repeat (H) @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++;
        if ({rx_data, rx_valid, tx_ready, miso, miso_oe, busy,
             overrun, underrun} !== 39'd0) begin
            errs++;
            $display("FAIL rst_mid: got %h want 0",
                     {rx_data, rx_valid, tx_ready, miso, miso_oe, busy,
                      overrun, underrun});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4 * H) @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_rearm: busy=%b want 0", busy);
        end
        ssel = 1'b1;
        prep(1'b1, 32'h5A, 32'h0, 1);
        spi_frame(MODE0, 5'd7, 8, 8, 32'hC3, 32'h0, r0, r1);
        vecs++;
        if ((rx_log.size() == 1 ? rx_log[0] : 32'hDEAD) !== 32'hC3) begin
            errs++;
            $display("FAIL rst_rx: got %p want c3", rx_log);
        end
        vecs++;
        if (r0[7:0] !== 8'h5A) begin
            errs++;
            $display("FAIL rst_miso: got %h want 5a", r0[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_overrun();
        test_underrun();
        test_abort();
        test_min_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_slave_stream.md
# spi_slave_stream

Runtime-configurable SPI slave that runs entirely in the `clk` domain. It sits between an external SPI master and on-chip valid/ready streams. `ssel`, `sclk` and `mosi` are oversampled through a synchronizer, and SCLK edges are detected as single-cycle enables. SPI mode and word length are selected per frame, received words arrive on an rx stream, and transmit words are drawn from a tx stream, with overrun and underrun detection.

## Interface
- `MaxWidth`, 32, widest supported word; shift registers and data ports are this width.
- `LenWidth`, 5, width of `cfg_len_m1`; must satisfy 2^LenWidth ≥ MaxWidth.
- `SyncStages`, 2, synchronizer depth for `ssel`/`sclk`/`mosi`; minimum 2.
- `SPOL`, 0, `ssel` active level.
- `MSB_FIRST`, 1, nonzero: bit `len-1` is shifted first; zero: bit 0 first.
- `FillValue`, 0, miso word sent on underrun (MaxWidth bits).
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cfg_cpol` in 1: SCLK idle level; latched at frame start.
- `cfg_cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge. Latched at frame start.
- `cfg_len_m1` in LenWidth: word length minus 1; latched at frame start; values ≥ MaxWidth clamp to MaxWidth-1; 0 is treated as 1 (minimum 2 bits).
- `rx_data` out MaxWidth: received word, right-justified, upper bits 0.
- `rx_valid` out 1: `rx_data` holds a word; held until `rx_ready`.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `tx_data` in MaxWidth: next word to transmit, right-justified.
- `tx_valid` in 1: `tx_data` is available.
- `tx_ready` out 1: one-cycle pulse; `tx_data` consumed this cycle.
- `ssel`, `sclk`, `mosi` in 1: SPI pins, asynchronous to `clk`.
- `miso` out 1: serial data out; 0 when deselected.
- `miso_oe` out 1: high while the frame is active (for the pad tristate).
- `busy` out 1: the state machine is not in IDLE.
- `overrun`, `underrun` out 1: sticky error flags.
- `err_clear` in 1: clears both sticky flags.

## Operation
- Inputs pass through the `synchronizer`. `sclk_q` is the registered previous synchronized value.
- `lead` = synchronized change away from `cpol_l`; `trail` = change back to it. Both are single-`clk` enables.
- Sample event = `lead` if `cpha_l`=0, else `trail`. Shift event = the other edge.
- States:
  - IDLE: on `ssel` active → LOAD.
  - LOAD (1 cycle):
    - Latch `cfg_*`, clear the bit counter.
    - Load the tx shift register: if `tx_valid`, load `tx_data` and pulse `tx_ready`; else load `FillValue` and set `underrun`.
    - → SHIFT.
  - SHIFT:
    - Sample: shift `mosi` into the rx register; the counter increments.
    - On the len-th sample the word is complete and the counter wraps to 0.
    - Shift: advance the tx register. The first shift event after a word completes reloads it instead, using the LOAD rules.
    - With cpha=1, the first leading edge of the frame is the shift that presents bit 0. No reload occurs on that edge.
    - `ssel` inactive → IDLE from any state. A partial rx word is discarded, and a tx word already accepted is not re-presented.
- Word complete:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: `rx_data` ← word, `rx_valid`=1.
  - Otherwise the new word is dropped, `rx_data` is unchanged and `overrun` is set.
- `miso` = tx register bit (`len-1` if MSB_FIRST, else bit 0) while in LOAD or SHIFT.
- Configuration changes mid-frame have no effect.

## Timing
- Reset values:
  - Data and status outputs: `rx_data`=0, `rx_valid`=0, `tx_ready`=0, `miso`=0, `miso_oe`=0, `busy`=0, `overrun`=0, `underrun`=0.
  - State = IDLE.
- Reset asserted mid-frame: the frame is abandoned. After release, the block waits for `ssel` inactive and then active again before starting a new frame.
- Pin-to-enable latency: SyncStages+1 `clk` cycles.
- `rx_valid` rises SyncStages+2 cycles after the final sampling edge at the pin.
- `miso` updates SyncStages+2 cycles after the shift edge at the pin.
- First `miso` bit is valid SyncStages+2 cycles after `ssel` asserts.
- Required: each SCLK phase ≥ SyncStages+3 `clk` periods (`clk` ≥ 10× `sclk` at SyncStages=2).
- Flag rule: `err_clear` and an error event in the same cycle leave the flag set.

## Configuration
- `SPI_SLAVE_STREAM_ERR_EN`
  - Defined: `overrun`/`underrun` are set and cleared as specified.
  - Undefined: both are tied to 0 and `err_clear` is ignored; the data path behaviour (drop-on-overrun, fill-on-underrun) is unchanged.

## Structure
- `spi_pkg`: state encoding (IDLE, LOAD, SHIFT) and the mode constants MODE0–MODE3 (mode = cpol*2+cpha), shared with testbenches.
- Sub-module: the existing `synchronizer` (Width 3, Stages `SyncStages`). No other hierarchy.

## Test plan
- Mode 0, len 8, `tx_data`=0xA5, master sends 0x3C → `rx_data`=0x3C with one `rx_valid`; master reads 0xA5; one `tx_ready` pulse.
- Mode 3, len 16, two back-to-back words 0x1234/0xBEEF, tx 0xCAFE/0x0F0F, `rx_ready` held 1 → rx 0x1234 then 0xBEEF; master reads 0xCAFE then 0x0F0F; no flags set.
- Mode 1, len 8, two words, `rx_ready`=0 → first word held, second word dropped, `overrun`=1. Then `err_clear` pulse → `overrun`=0.
- `tx_valid`=0 at `ssel` assert, FillValue=0 → master reads 0x00; `underrun`=1; `tx_ready` never pulses.
- Mode 2, len 5, `ssel` deasserted after 3 bits → no `rx_valid`, `busy`→0. The next full frame of 0x15 yields `rx_data`=0x15.
- `reset` low mid-word → all outputs reach their reset values immediately. A new frame after release completes correctly.
